serial_subtractor: RTL

Multi-cycle, bit-serial companion to the combinational 4-bit adder. It computes diff = a - b - bin, LSB first, one bit per clock. It uses a valid/ready handshake on the input side and on the result side. It slots into the same arithmetic datapath wherever an area-cheap subtract with a borrow chain is needed.

---
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing diff = a - b - bin, LSB first, one bit
//   per clock. Operands are accepted with a valid/ready handshake and the
//   result is offered with a second valid/ready handshake.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid && ready are both high. The producer holds valid (and its
//   data) until that edge, and ready never depends on valid.
//
//   Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the ovf output
//   (two's-complement overflow of the subtraction).
//
// Parameters:
//   WIDTH      operand/result width, 2..16
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/bin are valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       minuend / subtrahend, sampled on the input handshake
//   bin        borrow in, sampled on the input handshake
//   out_valid  diff/bout hold a completed result
//   out_ready  consumer accepts the result
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       borrow out, 1 iff a < b + bin (unsigned)
//   ovf        signed overflow (only with SERIAL_SUB_OVERFLOW_EN)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // State is kept in a named enum register so checkers can bind to it.
    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;
    logic             in_fire;
    logic             out_fire;

    // One full-subtractor slice working on the current LSBs.
    assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign in_ready = (state == IDLE);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire)  state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    // Result bits enter from the MSB side so that after
                    // WIDTH shifts bit 0 sits in res_sh[0].
                    res_sh <= {d_bit, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        diff      <= {d_bit, res_sh[WIDTH-1:1]};
                        bout      <= br_nxt;
                        out_valid <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // br is the borrow into the MSB slice, br_nxt the
                        // borrow out of it.
                        ovf       <= br ^ br_nxt;
`endif
                    end
                end
                DONE: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
